lights_out_board: RTL and testbench

//  Consumer end of the cursor interface: takes the 6-bit cursor Position and the Toggle button from the grid counter.

---
 rtl/lights_out_pkg.sv | 24 ++
 rtl/lights_out_mask.sv | 31 +++
 rtl/lights_out_board.sv | 134 +++++++++++++
 tb/tb_lights_out_board.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lights_out_pkg.sv
// Shared definitions for the Lights Out board: grid geometry, FSM state
// encoding and the row/column to bit-index mapping used by the board vector.
package lights_out_pkg;

    localparam int ROW_BITS = 3;
    localparam int COL_BITS = 3;
    localparam int ROWS     = 1 << ROW_BITS;
    localparam int COLS     = 1 << COL_BITS;
    localparam int CELLS    = ROWS * COLS;
    localparam int POS_W    = ROW_BITS + COL_BITS;

    typedef enum logic [1:0] {
        S_PLAY  = 2'd0,
        S_APPLY = 2'd1,
        S_CHECK = 2'd2,
        S_WON   = 2'd3
    } state_t;

    // Board bit index of cell (row, col); rows are stored as contiguous bytes.
    function automatic int cell_idx(input int row, input int col);
        return row * COLS + col;
    endfunction

endpackage

// File: rtl/lights_out_mask.sv
// Toggle mask generator.
// Ports:
//   pos  in  POS_W  cursor cell; row = upper ROW_BITS, col = lower COL_BITS
//   mask out CELLS  1 for the cursor cell and its in-grid orthogonal neighbours
// Neighbours that would fall off the grid are omitted (no wrap-around).
module lights_out_mask
    import lights_out_pkg::*;
(
    input  logic [POS_W-1:0] pos,
    output logic [CELLS-1:0] mask
);

    int row_s;
    int col_s;

    assign row_s = 32'(pos[POS_W-1:COL_BITS]);
    assign col_s = 32'(pos[COL_BITS-1:0]);

    // Each bit asks "am I the cursor or a neighbour that exists on the grid?"
    always_comb begin
        mask = {CELLS{1'b0}};
        for (int i = 0; i < CELLS; i++) begin
            mask[i] = (i == cell_idx(row_s, col_s))
                   || ((row_s > 32'sd0)        && (i == cell_idx(row_s - 32'sd1, col_s)))
                   || ((row_s < ROWS - 32'sd1) && (i == cell_idx(row_s + 32'sd1, col_s)))
                   || ((col_s > 32'sd0)        && (i == cell_idx(row_s, col_s - 32'sd1)))
                   || ((col_s < COLS - 32'sd1) && (i == cell_idx(row_s, col_s + 32'sd1)));
        end
    end

endmodule

// File: rtl/lights_out_board.sv
// Lights Out game board: 8x8 light state, move counter and solved flag,
// driven by the cursor Position and Toggle button.
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   Position    cursor cell (row = upper bits, col = lower bits)
//   Toggle      level button; one move per rising edge
//   Load        one-cycle strobe loading Pattern as a new puzzle
//   Pattern     puzzle to load, bit index = row*8+col
//   Board       current lights, 1 = on
//   Moves       accepted moves since last Load/reset, saturating
//   Won         board solved, held until Load/reset
//   Busy        FSM is not idle in S_PLAY
module lights_out_board #(
    parameter int ROW_BITS = lights_out_pkg::ROW_BITS,
    parameter int COL_BITS = lights_out_pkg::COL_BITS,
    parameter int MOVE_W   = 10,
    parameter logic [lights_out_pkg::CELLS-1:0] INIT_PATTERN = 64'h0000_0018_1800_0000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [ROW_BITS+COL_BITS-1:0]      Position,
    input  logic                              Toggle,
    input  logic                              Load,
    input  logic [lights_out_pkg::CELLS-1:0]  Pattern,
    output logic [lights_out_pkg::CELLS-1:0]  Board,
    output logic [MOVE_W-1:0]                 Moves,
    output logic                              Won,
    output logic                              Busy
);

    import lights_out_pkg::*;

    state_t                         state_r;
    state_t                         state_nx_s;
    logic                           toggle_q_r;
    logic                           toggle_edge_s;
    logic                           accept_s;
    logic [ROW_BITS+COL_BITS-1:0]   pos_q_r;
    logic [CELLS-1:0]               mask_s;
    logic [CELLS-1:0]               board_r;
    logic [MOVE_W-1:0]              moves_r;
    logic                           won_r;
    logic                           busy_r;

    assign toggle_edge_s = Toggle & ~toggle_q_r;

    lights_out_mask u_mask (
        .pos  (pos_q_r),
        .mask (mask_s)
    );

    // Next-state logic and move acceptance.
    // S_CHECK can take a fresh edge directly so a press two edges after the
    // previous one is not lost; the solved check has priority over it.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        if (Load) begin
            state_nx_s = S_PLAY;
        end else begin
            case (state_r)
                S_PLAY: begin
                    if (toggle_edge_s) begin
                        state_nx_s = S_APPLY;
                        accept_s   = 1'b1;
                    end else begin
                        state_nx_s = S_PLAY;
                    end
                end
                S_APPLY: state_nx_s = S_CHECK;
                S_CHECK: begin
                    if (board_r == {CELLS{1'b0}}) begin
                        state_nx_s = S_WON;
                    end else if (toggle_edge_s) begin
                        state_nx_s = S_APPLY;
                        accept_s   = 1'b1;
                    end else begin
                        state_nx_s = S_PLAY;
                    end
                end
                S_WON:   state_nx_s = S_WON;
                default: state_nx_s = S_PLAY;
            endcase
        end
    end

    // Toggle history for rising-edge detection.
    always_ff @(posedge clk) begin
        if (reset) toggle_q_r <= 1'b0;
        else       toggle_q_r <= Toggle;
    end

    // State register; Busy is registered from the next state so it tracks state_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_PLAY;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != S_PLAY);
        end
    end

    // Cursor capture on an accepted edge only.
    always_ff @(posedge clk) begin
        if (reset)         pos_q_r <= {(ROW_BITS+COL_BITS){1'b0}};
        else if (accept_s) pos_q_r <= Position;
    end

    // Board, move counter and solved flag; Load discards any in-flight move.
    always_ff @(posedge clk) begin
        if (reset) begin
            board_r <= INIT_PATTERN;
            moves_r <= {MOVE_W{1'b0}};
            won_r   <= 1'b0;
        end else if (Load) begin
            board_r <= Pattern;
            moves_r <= {MOVE_W{1'b0}};
            won_r   <= 1'b0;
        end else begin
            if (state_r == S_APPLY) begin
                board_r <= board_r ^ mask_s;
                if (moves_r != {MOVE_W{1'b1}}) moves_r <= moves_r + MOVE_W'(1);
            end
            if ((state_r == S_CHECK) && (board_r == {CELLS{1'b0}})) won_r <= 1'b1;
        end
    end

    assign Board = board_r;
    assign Moves = moves_r;
    assign Won   = won_r;
    assign Busy  = busy_r;

endmodule

// File: tb/tb_lights_out_board.sv
module tb_lights_out_board;

    localparam int OP_LOAD  = 0;
    localparam int OP_PRESS = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  Position = 6'd0;
    logic        Toggle = 1'b0;
    logic        Load = 1'b0;
    logic [63:0] Pattern = 64'd0;
    logic [63:0] Board, Board2;
    logic [9:0]  Moves;
    logic [1:0]  Moves2;
    logic        Won, Won2, Busy, Busy2;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [63:0] m_board;
    int          m_moves;
    logic        m_won;

    lights_out_board dut (
        .clk(clk), .reset(reset), .Position(Position), .Toggle(Toggle), .Load(Load),
        .Pattern(Pattern), .Board(Board), .Moves(Moves), .Won(Won), .Busy(Busy)
    );

    lights_out_board #(.MOVE_W(2)) dut_sat (
        .clk(clk), .reset(reset), .Position(Position), .Toggle(Toggle), .Load(Load),
        .Pattern(Pattern), .Board(Board2), .Moves(Moves2), .Won(Won2), .Busy(Busy2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          op;
        int          pos;
        logic [63:0] pat;
        logic [63:0] exp_board;
        int          exp_moves;
        logic        exp_won;
    } vec_t;

    vec_t tbl [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Cells within Manhattan distance 1 of p, computed from row/col geometry.
    function automatic logic [63:0] ref_mask(input int p);
        logic [63:0] m;
        int r, c, dr, dc;
        m = 64'd0;
        r = p / 8;
        c = p % 8;
        for (int k = 0; k < 64; k++) begin
            dr = k / 8 - r;
            dc = k % 8 - c;
            if (dr < 0) dr = -dr;
            if (dc < 0) dc = -dc;
            if (dr + dc <= 1) m[k] = 1'b1;
        end
        return m;
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_load(input logic [63:0] p);
        m_board = p;
        m_moves = 0;
        m_won   = 1'b0;
    endtask

    task automatic model_press(input int p);
        if (!m_won) begin
            m_board = m_board ^ ref_mask(p);
            m_moves++;
            if (m_board == 64'd0) m_won = 1'b1;
        end
    endtask

    task automatic do_load(input logic [63:0] p);
        Toggle  = 1'b0;
        Pattern = p;
        Load    = 1'b1;
        tick();
        Load    = 1'b0;
        tick();
    endtask

    // Press with the button held for hold cycles; cursor wanders after the edge.
    task automatic do_press(input int p, input int hold);
        Position = 6'(p);
        Toggle   = 1'b1;
        tick();
        Position = 6'($urandom_range(0, 63));
        repeat (hold - 1) tick();
        Toggle = 1'b0;
        repeat (3) tick();
    endtask

    task automatic check_all(input string tag, input logic [63:0] eb, input int em, input logic ew);
        chk({tag, ".board"},  Board,          eb);
        chk({tag, ".moves"},  {54'd0, Moves}, 64'(sat(em, 1023)));
        chk({tag, ".won"},    {63'd0, Won},   {63'd0, ew});
        chk({tag, ".busy"},   {63'd0, Busy},  {63'd0, ew});
        chk({tag, ".board2"}, Board2,         eb);
        chk({tag, ".moves2"}, {62'd0, Moves2}, 64'(sat(em, 3)));
        chk({tag, ".won2"},   {63'd0, Won2},  {63'd0, ew});
        chk({tag, ".busy2"},  {63'd0, Busy2}, {63'd0, ew});
    endtask

    initial begin
        logic [63:0] pat;
        logic [63:0] exp_b;
        int sel, kind, p, hold;

        tbl[0]  = '{OP_LOAD,  0, 64'h0,                   64'h0,                   0, 1'b0};
        tbl[1]  = '{OP_PRESS, 0, 64'h0,                   64'h0000_0000_0000_0103, 1, 1'b0};
        tbl[2]  = '{OP_PRESS, 27, 64'h0,                  64'h0000_0008_1C08_0103, 2, 1'b0};
        tbl[3]  = '{OP_LOAD,  0, 64'h0,                   64'h0,                   0, 1'b0};
        tbl[4]  = '{OP_PRESS, 63, 64'h0,                  64'hC080_0000_0000_0000, 1, 1'b0};
        tbl[5]  = '{OP_PRESS, 7, 64'h0,                   64'hC080_0000_0000_80C0, 2, 1'b0};
        tbl[6]  = '{OP_LOAD,  0, 64'h0000_0000_0000_0103, 64'h0000_0000_0000_0103, 0, 1'b0};
        tbl[7]  = '{OP_PRESS, 0, 64'h0,                   64'h0,                   1, 1'b1};
        tbl[8]  = '{OP_PRESS, 5, 64'h0,                   64'h0,                   1, 1'b1};
        tbl[9]  = '{OP_LOAD,  0, 64'h0000_0018_1800_0000, 64'h0000_0018_1800_0000, 0, 1'b0};
        tbl[10] = '{OP_PRESS, 36, 64'h0,                  64'h0000_1020_0800_0000, 1, 1'b0};
        tbl[11] = '{OP_PRESS, 27, 64'h0,                  64'h0000_1028_1408_0000, 2, 1'b0};
        tbl[12] = '{OP_LOAD,  0, 64'h0,                   64'h0,                   0, 1'b0};

        // reset state
        tick();
        tick();
        check_all("reset", 64'h0000_0018_1800_0000, 0, 1'b0);
        reset = 1'b0;
        tick();

        // directed table
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].op == OP_LOAD) do_load(tbl[i].pat);
            else                      do_press(tbl[i].pos, 1);
            check_all($sformatf("tbl%0d", i), tbl[i].exp_board, tbl[i].exp_moves, tbl[i].exp_won);
        end

        // latency: board/moves at N+1, busy through N+1, idle at N+2
        do_load(64'h0);
        Position = 6'd0;
        Toggle = 1'b1;
        tick();
        chk("lat.n.busy",   {63'd0, Busy}, 64'd1);
        chk("lat.n.board",  Board, 64'h0);
        tick();
        chk("lat.n1.board", Board, 64'h103);
        chk("lat.n1.moves", {54'd0, Moves}, 64'd1);
        chk("lat.n1.busy",  {63'd0, Busy}, 64'd1);
        Toggle = 1'b0;
        tick();
        chk("lat.n2.busy",  {63'd0, Busy}, 64'd0);

        // held toggle is one move; press at N+2 is accepted
        do_load(64'h0);
        Position = 6'd9;
        Toggle = 1'b1;
        repeat (20) tick();
        Toggle = 1'b0;
        repeat (3) tick();
        check_all("held", ref_mask(9), 1, 1'b0);
        Position = 6'd18;
        Toggle = 1'b1;
        tick();
        Position = 6'd45;
        Toggle = 1'b0;
        tick();
        Position = 6'd36;
        Toggle = 1'b1;
        tick();
        chk("n2.busy", {63'd0, Busy}, 64'd1);
        Toggle = 1'b0;
        repeat (3) tick();
        check_all("n2", ref_mask(9) ^ ref_mask(18) ^ ref_mask(36), 3, 1'b0);

        // Won timing: asserts two edges after toggle_edge
        do_load(64'h103);
        Position = 6'd0;
        Toggle = 1'b1;
        tick();
        chk("won.n",  {63'd0, Won}, 64'd0);
        tick();
        chk("won.n1", {63'd0, Won}, 64'd0);
        chk("won.n1.board", Board, 64'h0);
        tick();
        chk("won.n2", {63'd0, Won}, 64'd1);
        Toggle = 1'b0;
        tick();
        do_press(12, 2);
        check_all("won.ignore", 64'h0, 1, 1'b1);

        // Load coinciding with toggle_edge wins
        do_load(64'h0);
        Position = 6'd0;
        Toggle = 1'b1;
        Pattern = 64'h0000_0000_0000_00FF;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        repeat (3) tick();
        Toggle = 1'b0;
        tick();
        check_all("ld_edge", 64'hFF, 0, 1'b0);

        // Load while in S_APPLY discards the in-flight move
        Position = 6'd20;
        Toggle = 1'b1;
        tick();
        Toggle = 1'b0;
        Pattern = 64'h1234_5678_9ABC_DEF0;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        repeat (3) tick();
        check_all("ld_apply", 64'h1234_5678_9ABC_DEF0, 0, 1'b0);

        // reset while in S_APPLY
        Position = 6'd33;
        Toggle = 1'b1;
        tick();
        Toggle = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all("rst_apply", 64'h0000_0018_1800_0000, 0, 1'b0);
        repeat (3) tick();
        check_all("rst_after", 64'h0000_0018_1800_0000, 0, 1'b0);

        // saturation on the MOVE_W=2 instance
        do_load(64'h0);
        exp_b = 64'h0;
        for (int i = 0; i < 5; i++) begin
            do_press(i * 9, 1);
            exp_b = exp_b ^ ref_mask(i * 9);
        end
        check_all("sat", exp_b, 5, 1'b0);

        // randomized operations against the reference model
        do_load(64'h0);
        model_load(64'h0);
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 2) begin
                kind = $urandom_range(0, 3);
                case (kind)
                    0: pat = {$urandom, $urandom};
                    1: pat = ref_mask($urandom_range(0, 63));
                    2: pat = ref_mask($urandom_range(0, 63)) ^ ref_mask($urandom_range(0, 63));
                    default: pat = 64'h0;
                endcase
                do_load(pat);
                model_load(pat);
            end else begin
                p = $urandom_range(0, 63);
                hold = $urandom_range(1, 4);
                do_press(p, hold);
                model_press(p);
            end
            check_all($sformatf("rnd%0d", n), m_board, m_moves, m_won);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
